// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO with fill level, flush and threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo_fwft #(
    parameter int fifo_data_size      = 8,
    parameter int fifo_ptr_size       = 4,
    parameter int almost_full_margin  = 2,
    parameter int almost_empty_margin = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      wr_valid,
    input  logic [fifo_data_size-1:0] wr_data,
    input  logic                      rd_valid,
    input  logic                      err_clr,
    output logic [fifo_data_size-1:0] rd_data,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic                      fifo_almost_full,
    output logic                      fifo_almost_empty,
    output logic [fifo_ptr_size:0]    fifo_level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int DEPTH    = 1 << fifo_ptr_size;
    localparam int AF_LEVEL = DEPTH - almost_full_margin;
    localparam int AE_LEVEL = almost_empty_margin;

    localparam logic [fifo_ptr_size-1:0] PTR_ONE   = 1;
    localparam logic [fifo_ptr_size:0]   LEVEL_ONE = 1;
    localparam logic [fifo_ptr_size:0]   LEVEL_MAX = {1'b1, {fifo_ptr_size{1'b0}}};

    logic [fifo_data_size-1:0] mem_q [DEPTH];

    logic [fifo_ptr_size-1:0]  wr_ptr_q, wr_ptr_d;
    logic [fifo_ptr_size-1:0]  rd_ptr_q, rd_ptr_d;
    logic [fifo_ptr_size-1:0]  rd_ptr_inc;
    logic [fifo_ptr_size:0]    level_q, level_d;
    logic [fifo_data_size-1:0] rd_data_q, rd_data_d;

    logic full, empty;
    logic push_ok, pop_ok;

    // Handshake: wr_valid is a push request taken only when not full; rd_valid
    // acknowledges the word currently on rd_data and is taken only when not
    // empty. Neither side back-pressures through a combinational path.
    assign full  = (level_q == LEVEL_MAX);
    assign empty = (level_q == '0);

    assign push_ok    = wr_valid && !full  && !flush;
    assign pop_ok     = rd_valid && !empty && !flush;
    assign rd_ptr_inc = rd_ptr_q + PTR_ONE;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_inc;
        end

        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        // The head register must show the new word one cycle after a push into
        // an empty (or emptying) FIFO, so the write data bypasses the array.
        if (push_ok && (empty || (level_q == LEVEL_ONE && pop_ok))) begin
            rd_data_d = wr_data;
        end else if (pop_ok && level_q > LEVEL_ONE) begin
            rd_data_d = mem_q[rd_ptr_inc];
        end

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage carries no reset; only words below the level are ever read.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data           = rd_data_q;
    assign fifo_level        = level_q;
    assign fifo_full         = full;
    assign fifo_empty        = empty;
    assign fifo_almost_full  = (int'(level_q) >= AF_LEVEL);
    assign fifo_almost_empty = (int'(level_q) <= AE_LEVEL);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Set wins over clear; flush masks the requests so they raise nothing.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_valid && full && !flush) begin
            overflow_d = 1'b1;
        end
        if (rd_valid && empty && !flush) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed vector bench for sync_fifo_fwft at DEPTH = 4, margins 1/1.
// Error-flag expectations follow SYNC_FIFO_ERR_FLAGS_EN as seen by this bench.
module tb_sync_fifo_fwft;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic [2:0] fifo_level;
    logic       overflow, underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    sync_fifo_fwft #(
        .fifo_data_size     (8),
        .fifo_ptr_size      (2),
        .almost_full_margin (1),
        .almost_empty_margin(1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .rd_valid         (rd_valid),
        .err_clr          (err_clr),
        .rd_data          (rd_data),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .fifo_almost_empty(fifo_almost_empty),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .underflow        (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       f;
        logic       w;
        logic       r;
        logic       c;
        logic [7:0] din;
        int         lvl;
        logic [7:0] dout;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic f, logic w, logic r, logic c, logic [7:0] din,
                                int lvl, logic [7:0] dout, logic ov, logic un);
        vec_t v;
        v.f = f; v.w = w; v.r = r; v.c = c; v.din = din;
        v.lvl = lvl; v.dout = dout; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int act, int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags are derived from the expected level using the threshold definitions.
    task automatic check_state(string tag, int lvl, logic [7:0] dout, logic ov, logic un);
        check({tag, ".level"},  int'(fifo_level),        lvl);
        check({tag, ".empty"},  int'(fifo_empty),        int'(lvl == 0));
        check({tag, ".full"},   int'(fifo_full),         int'(lvl == 4));
        check({tag, ".afull"},  int'(fifo_almost_full),  int'(lvl >= 3));
        check({tag, ".aempty"}, int'(fifo_almost_empty), int'(lvl <= 1));
        check({tag, ".rdata"},  int'(rd_data),           int'(dout));
        check({tag, ".ovf"},    int'(overflow),          int'(ov & ERR_EN));
        check({tag, ".udf"},    int'(underflow),         int'(un & ERR_EN));
    endtask

    task automatic drive(logic rst_n, logic f, logic w, logic r, logic c, logic [7:0] din);
        @(negedge clk);
        reset_n  = rst_n;
        flush    = f;
        wr_valid = w;
        rd_valid = r;
        err_clr  = c;
        wr_data  = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   f  w  r  c  din    lvl dout   ov un
        add(0, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0);
        add(0, 1, 0, 0, 8'h22, 2, 8'h11, 0, 0);
        add(0, 1, 0, 0, 8'h33, 3, 8'h11, 0, 0);
        add(0, 1, 0, 0, 8'h44, 4, 8'h11, 0, 0);
        add(0, 1, 0, 0, 8'h55, 4, 8'h11, 1, 0);
        add(0, 0, 1, 0, 8'h00, 3, 8'h22, 1, 0);
        add(0, 0, 1, 0, 8'h00, 2, 8'h33, 1, 0);
        add(0, 0, 1, 0, 8'h00, 1, 8'h44, 1, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'h44, 1, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'h44, 1, 1);
        add(0, 0, 0, 0, 8'h00, 0, 8'h44, 1, 1);
        add(0, 0, 0, 1, 8'h00, 0, 8'h44, 0, 0);
        add(0, 0, 1, 1, 8'h00, 0, 8'h44, 0, 1);
        add(0, 0, 0, 1, 8'h00, 0, 8'h44, 0, 0);
        add(0, 1, 1, 0, 8'hAA, 1, 8'hAA, 0, 1);
        add(0, 0, 0, 1, 8'h00, 1, 8'hAA, 0, 0);
        add(0, 1, 0, 0, 8'hBB, 2, 8'hAA, 0, 0);
        add(0, 1, 0, 0, 8'hCC, 3, 8'hAA, 0, 0);
        add(0, 1, 0, 0, 8'hDD, 4, 8'hAA, 0, 0);
        add(0, 1, 1, 0, 8'hEE, 3, 8'hBB, 1, 0);
        add(0, 0, 1, 0, 8'h00, 2, 8'hCC, 1, 0);
        add(0, 0, 1, 0, 8'h00, 1, 8'hDD, 1, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'hDD, 1, 0);
        add(0, 1, 0, 0, 8'h01, 1, 8'h01, 1, 0);
        add(0, 1, 0, 0, 8'h02, 2, 8'h01, 1, 0);
        add(0, 1, 0, 0, 8'h03, 3, 8'h01, 1, 0);
        add(1, 1, 1, 0, 8'h99, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 1, 8'hA5, 1, 0);
        add(0, 1, 0, 0, 8'hB0, 2, 8'hA5, 1, 0);
        for (int k = 0; k < 10; k++) begin
            add(0, 1, 1, 0, 8'hC0 + 8'(k), 2, (k == 0) ? 8'hB0 : 8'hC0 + 8'(k - 1), 1, 0);
        end
        add(0, 0, 1, 0, 8'h00, 1, 8'hC9, 1, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'hC9, 1, 0);

        reset_n  = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        rd_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].din);
            check_state($sformatf("v%0d", i), vecs[i].lvl, vecs[i].dout, vecs[i].ov, vecs[i].un);
        end

        // Reset in the middle of traffic drops contents and error flags.
        drive(1'b1, 0, 1, 0, 0, 8'h12);
        drive(1'b1, 0, 1, 0, 0, 8'h13);
        check_state("pre_rst", 2, 8'h12, 1, 0);
        drive(1'b0, 0, 1, 1, 0, 8'h14);
        check_state("mid_rst", 0, 8'h00, 0, 0);
        drive(1'b1, 0, 1, 0, 0, 8'h34);
        check_state("post_rst", 1, 8'h34, 0, 0);
        drive(1'b1, 0, 0, 1, 0, 8'h00);
        check_state("post_rst_pop", 0, 8'h34, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, show-ahead (first-word-fall-through) FIFO, parametrised in data width, depth and almost-full/almost-empty thresholds. It adds a fill-level output, flush, and optional sticky overflow/underflow error flags. It is the general-purpose buffer for same-clock datapaths, such as pixel and line staging inside the video pipeline. It keeps the codebase FIFO port semantics: `rd_data` is valid whenever `fifo_empty` is low, and `rd_valid` pops the current word.

## Interface
- `fifo_data_size`, 8: width of each word.
- `fifo_ptr_size`, 4: log2 of capacity; DEPTH = 2**fifo_ptr_size words, and DEPTH ≥ 2.
- `almost_full_margin`, 2: `fifo_almost_full` is high when level ≥ DEPTH − almost_full_margin; range 0..DEPTH−1.
- `almost_empty_margin`, 1: `fifo_almost_empty` is high when level ≤ almost_empty_margin; range 0..DEPTH−1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous discard of all contents.
- `wr_valid`  in  1  push request.
- `wr_data`  in  fifo_data_size  push data.
- `rd_valid`  in  1  pop request (acknowledges the current `rd_data`).
- `err_clr`  in  1  clears the sticky error flags.
- `rd_data`  out  fifo_data_size  head word (show-ahead).
- `fifo_full`  out  1  level == DEPTH.
- `fifo_empty`  out  1  level == 0.
- `fifo_almost_full`  out  1  threshold flag.
- `fifo_almost_empty`  out  1  threshold flag.
- `fifo_level`  out  fifo_ptr_size+1  number of stored words, 0..DEPTH.
- `overflow`  out  1  sticky; a push was attempted while full.
- `underflow`  out  1  sticky; a pop was attempted while empty.

## Operation
- **Reset** (`reset_n` = 0 at an edge):
  - level = 0, `fifo_empty` = 1, `fifo_full` = 0, `fifo_almost_empty` = 1, `fifo_almost_full` = 0 (or 1 only if almost_full_margin ≥ DEPTH, which is illegal).
  - `rd_data` = 0, `overflow` = 0, `underflow` = 0.
  - Reset mid-operation discards all contents; reset beats every other input.
- **Push:** a push is accepted at an edge when `wr_valid` = 1 and `fifo_full` = 0, using the pre-edge value of `fifo_full`. A push while full is dropped, and the contents are unchanged.
- **Pop:** a pop is accepted when `rd_valid` = 1 and `fifo_empty` = 0. A pop while empty is ignored.
- **Simultaneous push and pop:**
  - When neither full nor empty, both are accepted and the level is unchanged.
  - When full, only the pop is accepted, giving level DEPTH−1.
  - When empty, only the push is accepted, giving level 1. The pushed word becomes `rd_data`.
- **Ordering:** strict FIFO order. Read/write pointers are fifo_ptr_size bits and wrap modulo DEPTH. The level is tracked separately, so full and empty are unambiguous.
- **`rd_data`:** shows the oldest stored word while non-empty. When empty, it holds the last popped word (0 after reset or flush).
- **Flush** (`flush` = 1 at an edge, `reset_n` = 1):
  - level = 0 and all flags take their reset values, except `overflow`/`underflow`, which are retained.
  - `wr_valid`/`rd_valid` in the same cycle are ignored and do not set the error flags.
- **Error flags:** `err_clr` = 1 clears both flags at the edge. If an error event occurs in the same cycle as `err_clr`, the flag is set (set wins).

## Timing
- All outputs are registered or decoded only from registers. There is no combinational path from any input to any output.
- **Write-to-read latency is 1 cycle.** A push accepted at edge N into an empty FIFO gives `fifo_empty` = 0 and `rd_data` = that word after edge N. This requires a bypass into the head register.
- **Pop:** a pop at edge N presents the next word on `rd_data` after edge N, with no bubble for back-to-back pops.
- Full sustained throughput is one push plus one pop per cycle.
- **Flag update:** `fifo_level` and all four flags update at the same edge as the accepted operation.

## Configuration
- Macro `SYNC_FIFO_ERR_FLAGS_EN`.
- **Defined:** `overflow`/`underflow` are implemented as described above.
- **Undefined:**
  - Both outputs are tied to 0.
  - `err_clr` is ignored.
  - No error registers are synthesised.
  - All other behaviour is identical.

## Test plan
All scenarios use fifo_ptr_size = 2 (DEPTH = 4), almost_full_margin = 1 and almost_empty_margin = 1.
- **Reset:** drive `reset_n` low for 2 edges while `wr_valid` = 1. Required: level 0, `fifo_empty` = 1, `fifo_almost_empty` = 1, `rd_data` = 0 and both error flags 0.
- **Fill to full, then overflow:** push 0x11, 0x22, 0x33, 0x44, then push 0x55.
  - After the first push: `rd_data` = 0x11 and `fifo_empty` = 0.
  - After the third push: `fifo_almost_full` = 1.
  - After the fourth push: `fifo_full` = 1 and level 4.
  - 0x55 is dropped and `overflow` = 1. Popping 4 times yields 0x11, 0x22, 0x33, 0x44.
- **Simultaneous push and pop:**
  - When full: level goes from 4 to 3 and the pushed word is not stored.
  - When empty: level goes from 0 to 1 and `rd_data` = the pushed word.
  - With level 2: level stays 2 for 10 back-to-back cycles, through pointer wrap-around, with order preserved.
- **Underflow and clear:**
  - Pop while empty: `underflow` = 1 and it stays 1.
  - `err_clr` alone: clears the flag.
  - `err_clr` together with an empty pop in the same cycle: `underflow` stays 1.
- **Flush:** with 3 words stored and `overflow` = 1, drive `flush` together with `wr_valid` and `rd_valid`. Required: level 0, `fifo_empty` = 1 and `overflow` still 1. The next push of 0xA5 appears on `rd_data` 1 cycle later.
- **Macro off:** repeat the overflow and underflow scenarios. Both flags must stay 0.
